// File: rtl/ir_buffer_loader.sv
// ir_buffer_loader: loads a block of instruction words from memory into a
// local register array on i_start, then serves 1-cycle random (i_ir_en) and
// sequential (i_ir_next) fetches. Reload is allowed from WORK.
// Optional parity storage/check is enabled by defining IR_BUFFER_PARITY_EN.
`timescale 1ns/1ps
module ir_buffer_loader #(
  parameter int DATA_WIDTH     = 16,
  parameter int IR_ADDR_WIDTH  = 6,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [MEM_ADDR_WIDTH-1:0] i_base_addr,
  input  logic [IR_ADDR_WIDTH:0]    i_load_len,
  output logic                      o_mem_req,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                      i_mem_ack,
  input  logic [DATA_WIDTH-1:0]     i_mem_data,
  output logic                      o_busy,
  output logic                      o_ready,
  input  logic                      i_ir_en,
  input  logic [IR_ADDR_WIDTH-1:0]  i_ir_addr,
  input  logic                      i_ir_next,
  output logic [IR_ADDR_WIDTH-1:0]  o_ir_addr,
  output logic [DATA_WIDTH-1:0]     o_ir_data,
  output logic                      o_ir_valid,
  output logic                      o_ir_err,
  output logic                      o_parity_err
);

  localparam int DEPTH = 2 ** IR_ADDR_WIDTH;
  localparam int CW    = IR_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WORK} state_t;

  state_t                    state, state_next;
  logic [CW-1:0]             len_q;
  logic [CW-1:0]             wr_cnt;
  logic [CW-1:0]             count;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [IR_ADDR_WIDTH-1:0]  ptr;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  logic                      start_ok;
  logic                      ack_ok;
  logic                      last_word;
  logic                      fetch_ok;
  logic                      rand_hit;
  logic                      seq_hit;
  logic                      ptr_wrap;
  logic [IR_ADDR_WIDTH-1:0]  wr_idx;

  // A start only counts outside LOAD; acks only count while requesting.
  assign start_ok  = i_start && (state != LOAD);
  assign ack_ok    = i_mem_ack && (state == LOAD);
  assign last_word = (wr_cnt == (len_q - CW'(1)));
  assign wr_idx    = wr_cnt[IR_ADDR_WIDTH-1:0];
  // Fetches issued in the same cycle as a (re)start are dropped.
  assign fetch_ok  = (state != LOAD) && !i_start;
  assign rand_hit  = ({1'b0, i_ir_addr} < count);
  assign seq_hit   = (count != '0);
  assign ptr_wrap  = (({1'b0, ptr} + CW'(1)) == count);

  assign o_mem_addr = mem_addr;
  assign o_ir_addr  = ptr;

  // State register; async reset aborts any load in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and state-decoded handshake/status outputs.
  always_comb begin
    state_next = state;
    o_mem_req  = 1'b0;
    o_busy     = 1'b0;
    o_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_next = (i_load_len == '0) ? WORK : LOAD;
      end
      LOAD: begin
        o_mem_req = 1'b1;
        o_busy    = 1'b1;
        if (i_mem_ack && last_word) state_next = WORK;
      end
      WORK: begin
        o_ready = 1'b1;
        if (i_start) state_next = (i_load_len == '0) ? WORK : LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Load bookkeeping (length, write index, address) and the sequential pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      wr_cnt   <= '0;
      count    <= '0;
      mem_addr <= '0;
      ptr      <= '0;
    end else if (start_ok) begin
      len_q  <= i_load_len;
      wr_cnt <= '0;
      count  <= '0;
      ptr    <= '0;
      if (i_load_len != '0) mem_addr <= i_base_addr;
    end else if (ack_ok) begin
      wr_cnt   <= last_word ? '0 : wr_cnt + CW'(1);
      mem_addr <= mem_addr + MEM_ADDR_WIDTH'(1);
      if (last_word) count <= len_q;
    end else if (fetch_ok && !i_ir_en && i_ir_next && seq_hit) begin
      ptr <= ptr_wrap ? '0 : ptr + IR_ADDR_WIDTH'(1);
    end
  end

  // Instruction array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ack_ok) mem[wr_idx] <= i_mem_data;
  end

  // Fetch port: random read has priority over sequential read; data holds between fetches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ir_data  <= '0;
      o_ir_valid <= 1'b0;
      o_ir_err   <= 1'b0;
    end else begin
      o_ir_valid <= 1'b0;
      o_ir_err   <= 1'b0;
      if (fetch_ok && i_ir_en) begin
        o_ir_valid <= 1'b1;
        if (rand_hit) begin
          o_ir_data <= mem[i_ir_addr];
        end else begin
          o_ir_data <= '0;
          o_ir_err  <= 1'b1;
        end
      end else if (fetch_ok && i_ir_next) begin
        o_ir_valid <= 1'b1;
        if (seq_hit) begin
          o_ir_data <= mem[ptr];
        end else begin
          o_ir_data <= '0;
          o_ir_err  <= 1'b1;
        end
      end
    end
  end

`ifdef IR_BUFFER_PARITY_EN
  logic par_mem [DEPTH];

  // Even-parity bit captured alongside each loaded word.
  always_ff @(posedge clk) begin
    if (ack_ok) par_mem[wr_idx] <= ^i_mem_data;
  end

  // Parity flag accompanies in-range fetches only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_parity_err <= 1'b0;
    end else begin
      o_parity_err <= 1'b0;
      if (fetch_ok && i_ir_en) begin
        if (rand_hit) o_parity_err <= ((^mem[i_ir_addr]) != par_mem[i_ir_addr]);
      end else if (fetch_ok && i_ir_next && seq_hit) begin
        o_parity_err <= ((^mem[ptr]) != par_mem[ptr]);
      end
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

endmodule
